jkff_bank_ctrl: RTL and testbench

JKFF_BANK_CTRL -- requirements
Module: jkff_bank_ctrl

---
 rtl/jkff_bank_ctrl.sv | 103 ++++++++++
 tb/tb_jkff_bank_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/jkff_bank_ctrl.sv
// Sequencer driving a 4-bit JK flip-flop bank through up, down, Gray and Johnson
// counts; J/K are derived from the desired next code with the excitation rule.
module jkff_bank_ctrl (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [1:0] Mode,
    input  logic [3:0] Steps,
    output logic [3:0] J,
    output logic [3:0] K,
    output logic [3:0] Q,
    output logic       Busy,
    output logic       Done
);

    // state   | meaning
    // IDLE    | bank holds, waiting for Start
    // RUN     | one bank update per cycle until the step counter hits zero
    // DONE    | single-cycle completion pulse, bank holds
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] q_q, q_d;
    logic [3:0] nxt;
    logic [3:0] gray_bin;
    logic [3:0] gray_bin_inc;
    logic [3:0] gray_nxt;
    logic [4:0] steps_ld;

    // Gray successor goes through the binary domain and back.
    assign gray_bin     = {q_q[3], ^q_q[3:2], ^q_q[3:1], ^q_q[3:0]};
    assign gray_bin_inc = gray_bin + 4'd1;
    assign gray_nxt     = gray_bin_inc ^ (gray_bin_inc >> 1);

    assign steps_ld = (Steps == 4'd0) ? 5'd16 : {1'b0, Steps};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        nxt     = q_q;
        J       = 4'b0000;
        K       = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    mode_d  = Mode;
                    cnt_d   = steps_ld;
                end
            end
            ST_RUN: begin
                case (mode_q)
                    2'b00:   nxt = q_q + 4'd1;
                    2'b01:   nxt = q_q - 4'd1;
                    2'b10:   nxt = gray_nxt;
                    default: nxt = {q_q[2:0], ~q_q[3]};
                endcase
                J     = ~q_q & nxt;
                K     = q_q & ~nxt;
                cnt_d = cnt_q - 5'd1;
                if (cnt_d == 5'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Characteristic equation of a JK flip-flop, applied per bit.
        q_d = (J & ~q_q) | (~K & q_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'b00;
            cnt_q   <= 5'd0;
            q_q     <= 4'b0000;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign Q    = q_q;
    assign Busy = (state_q == ST_RUN);
    assign Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_jkff_bank_ctrl.sv
// Directed self-checking bench for jkff_bank_ctrl with hand-computed expectations.
module tb_jkff_bank_ctrl;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [1:0] Mode;
    logic [3:0] Steps;
    logic [3:0] J;
    logic [3:0] K;
    logic [3:0] Q;
    logic       Busy;
    logic       Done;

    int n_checks;
    int n_fail;
    int busy_cycles;

    jkff_bank_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Mode  (Mode),
        .Steps (Steps),
        .J     (J),
        .K     (K),
        .Q     (Q),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Accept a run at the next edge; afterwards the block is in its first RUN cycle.
    task automatic start_run(input logic [1:0] m, input logic [3:0] s);
        Mode  = m;
        Steps = s;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        Start    = 1'b0;
        Mode     = 2'b00;
        Steps    = 4'd0;
        tick();
        tick();
        Reset = 1'b0;

        check_eq("rst_q", Q, 4'b0000);
        check_eq("rst_busy", Busy, 1'b0);
        check_eq("rst_done", Done, 1'b0);
        check_eq("rst_j", J, 4'b0000);
        check_eq("rst_k", K, 4'b0000);

        // Binary up, 3 steps
        start_run(2'b00, 4'd3);
        check_eq("up_busy0", Busy, 1'b1);
        check_eq("up_j0", J, 4'b0001);
        check_eq("up_k0", K, 4'b0000);
        tick(); check_eq("up_q1", Q, 4'b0001); check_eq("up_busy1", Busy, 1'b1);
        check_eq("up_k1", K, 4'b0001); check_eq("up_j1", J, 4'b0010);
        tick(); check_eq("up_q2", Q, 4'b0010);
        tick(); check_eq("up_q3", Q, 4'b0011);
        check_eq("up_done", Done, 1'b1);
        check_eq("up_busy_done", Busy, 1'b0);
        check_eq("up_j_done", J, 4'b0000);
        Start = 1'b1;  // ignored while in DONE
        tick();
        Start = 1'b0;
        check_eq("up_done_clr", Done, 1'b0);
        check_eq("up_start_in_done", Busy, 1'b0);
        tick();
        check_eq("up_idle_q", Q, 4'b0011);
        check_eq("up_idle_busy", Busy, 1'b0);

        // Binary down wraps 0000 -> 1111
        do_reset();
        start_run(2'b01, 4'd1);
        check_eq("dn_j", J, 4'b1111);
        check_eq("dn_k", K, 4'b0000);
        tick();
        check_eq("dn_q", Q, 4'b1111);
        check_eq("dn_done", Done, 1'b1);
        tick();

        // Gray up
        do_reset();
        start_run(2'b10, 4'd3);
        tick(); check_eq("gr_q1", Q, 4'b0001);
        tick(); check_eq("gr_q2", Q, 4'b0011);
        tick(); check_eq("gr_q3", Q, 4'b0010);
        check_eq("gr_done", Done, 1'b1);
        tick();

        // Gray wrap 1000 -> 0000
        do_reset();
        start_run(2'b10, 4'd15);
        for (int i = 0; i < 15; i++) tick();
        check_eq("gr15_q", Q, 4'b1000);
        check_eq("gr15_done", Done, 1'b1);
        tick();
        start_run(2'b10, 4'd1);
        check_eq("grw_k", K, 4'b1000);
        tick();
        check_eq("grw_q", Q, 4'b0000);
        tick();

        // Johnson ring
        do_reset();
        start_run(2'b11, 4'd5);
        tick(); check_eq("jn_q1", Q, 4'b0001);
        tick(); check_eq("jn_q2", Q, 4'b0011);
        tick(); check_eq("jn_q3", Q, 4'b0111);
        check_eq("jn_j3", J, 4'b1000);
        tick(); check_eq("jn_q4", Q, 4'b1111);
        check_eq("jn_j4", J, 4'b0000);
        check_eq("jn_k4", K, 4'b0001);
        tick(); check_eq("jn_q5", Q, 4'b1110);
        check_eq("jn_done", Done, 1'b1);
        tick();

        // Reach 0101, then a 16-step run (Steps=0) with a mid-run Start
        do_reset();
        start_run(2'b00, 4'd5);
        for (int i = 0; i < 5; i++) tick();
        check_eq("pre16_q", Q, 4'b0101);
        tick();
        start_run(2'b00, 4'd0);
        busy_cycles = 0;
        for (int i = 0; i < 40 && Busy; i++) begin
            if (i == 8) begin
                Start = 1'b1;
                Mode  = 2'b11;
                Steps = 4'd2;
            end else begin
                Start = 1'b0;
            end
            busy_cycles++;
            tick();
        end
        Start = 1'b0;
        check_eq("s16_busy_cycles", busy_cycles, 16);
        check_eq("s16_q", Q, 4'b0101);
        check_eq("s16_done", Done, 1'b1);
        tick();
        check_eq("s16_idle_busy", Busy, 1'b0);
        check_eq("s16_idle_done", Done, 1'b0);

        // Johnson rule applied to a non-Johnson code
        start_run(2'b11, 4'd1);
        check_eq("jnx_j", J, 4'b1010);
        check_eq("jnx_k", K, 4'b0100);
        tick();
        check_eq("jnx_q", Q, 4'b1011);
        tick();

        // Reset on the second RUN edge aborts the run
        do_reset();
        start_run(2'b00, 4'd8);
        tick();
        check_eq("ab_q1", Q, 4'b0001);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_eq("ab_q", Q, 4'b0000);
        check_eq("ab_busy", Busy, 1'b0);
        check_eq("ab_j", J, 4'b0000);
        check_eq("ab_k", K, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            check_eq("ab_no_done", Done, 1'b0);
            tick();
        end
        check_eq("ab_q_hold", Q, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
